// File: rtl/ili9163_pkg.sv
// Shared command codes, FSM state encoding and default pixel width for the
// ILI9163 SPI sink.
package ili9163_pkg;
  localparam int PIXEL_SIZE_DEF = 16;

  localparam logic [7:0] CMD_CASET = 8'h2A;
  localparam logic [7:0] CMD_RASET = 8'h2B;
  localparam logic [7:0] CMD_RAMWR = 8'h2C;

  typedef enum logic [2:0] {IDLE, CASET, RASET, RAMWR, IGNORE} state_t;
endpackage

// File: rtl/ili9163_spi_sink_if.sv
// SPI link from the display controller plus the frame-buffer write port and
// status strobes of the sink.
interface ili9163_spi_sink_if #(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int PIXEL_SIZE = 16
);
  localparam int AW = $clog2(WIDTH * HEIGHT);

  logic                  spi_mosi;
  logic                  spi_sck;
  logic                  spi_cs;
  logic                  spi_dc;
  logic                  pix_we;
  logic [AW-1:0]         pix_addr;
  logic [PIXEL_SIZE-1:0] pix_data;
  logic                  cmd_valid;
  logic [7:0]            cmd_byte;
  logic                  frame_done;
  logic                  err_partial;

  modport slave (
    input  spi_mosi, spi_sck, spi_cs, spi_dc,
    output pix_we, pix_addr, pix_data, cmd_valid, cmd_byte, frame_done, err_partial
  );

  modport master (
    output spi_mosi, spi_sck, spi_cs, spi_dc,
    input  pix_we, pix_addr, pix_data, cmd_valid, cmd_byte, frame_done, err_partial
  );
endinterface

// File: rtl/ili9163_spi_sink_rx.sv
// SPI mode-0 byte receiver: synchronises the raw pins into clk, detects sck
// rising edges and assembles MSB-first bytes tagged with the dc level.
module spi_byte_rx (
  input  logic       clk,
  input  logic       rst,
  input  logic       sck,
  input  logic       cs,
  input  logic       mosi,
  input  logic       dc,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_dc,
  output logic       cs_end,
  output logic       cs_end_partial
);
  logic       sck_p0, sck_p1, sck_p2;
  logic       cs_p0, cs_p1, cs_p2;
  logic       mosi_p0, mosi_p1;
  logic       dc_p0, dc_p1;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic       sck_rise;
  logic       cs_rise;
  logic       sample;

  assign sck_rise = sck_p1 & ~sck_p2;
  assign cs_rise  = cs_p1 & ~cs_p2;
  assign sample   = ~cs_p1 & sck_rise;

  // p0/p1 synchronise, p2 holds the previous level for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sck_p0         <= 1'b0;
      sck_p1         <= 1'b0;
      sck_p2         <= 1'b0;
      cs_p0          <= 1'b1;
      cs_p1          <= 1'b1;
      cs_p2          <= 1'b1;
      bit_cnt        <= 3'd0;
      byte_valid     <= 1'b0;
      cs_end         <= 1'b0;
      cs_end_partial <= 1'b0;
    end else begin
      sck_p0         <= sck;
      sck_p1         <= sck_p0;
      sck_p2         <= sck_p1;
      cs_p0          <= cs;
      cs_p1          <= cs_p0;
      cs_p2          <= cs_p1;
      byte_valid     <= 1'b0;
      cs_end         <= cs_rise;
      cs_end_partial <= cs_rise && (bit_cnt != 3'd0);
      if (sample) begin
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) byte_valid <= 1'b1;
      end else if (cs_p1) begin
        bit_cnt <= 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    mosi_p0 <= mosi;
    mosi_p1 <= mosi_p0;
    dc_p0   <= dc;
    dc_p1   <= dc_p0;
    if (sample) begin
      shift <= {shift[5:0], mosi_p1};
      if (bit_cnt == 3'd7) begin
        byte_data <= {shift, mosi_p1};
        byte_dc   <= dc_p1;
      end
    end
  end
endmodule

// File: rtl/ili9163_spi_sink.sv
// ILI9163 panel stand-in: decodes CASET/RASET/RAMWR from the SPI byte stream
// and writes each RAMWR pixel into a frame buffer at row*WIDTH+col.
module ili9163_spi_sink
  import ili9163_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int PIXEL_SIZE = PIXEL_SIZE_DEF
) (
  input logic               clk,
  input logic               rst,
  ili9163_spi_sink_if.slave bus
);
  localparam int AW = $clog2(WIDTH * HEIGHT);
  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);

  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_dc;
  logic                  cs_end;
  logic                  cs_end_partial;

  state_t                state;
  logic [1:0]            param_cnt;
  logic [15:0]           start_w;
  logic [7:0]            end_hi;
  logic [15:0]           xs, xe, ys, ye;
  logic [15:0]           col, row;
  logic                  half;
  logic [7:0]            hi_byte;
  logic [15:0]           pix_word;
  logic                  in_bounds;

  logic                  pix_we;
  logic [AW-1:0]         pix_addr;
  logic [PIXEL_SIZE-1:0] pix_data;
  logic                  cmd_valid;
  logic [7:0]            cmd_byte;
  logic                  frame_done;
  logic                  err_partial;

  spi_byte_rx u_rx (
    .clk           (clk),
    .rst           (rst),
    .sck           (bus.spi_sck),
    .cs            (bus.spi_cs),
    .mosi          (bus.spi_mosi),
    .dc            (bus.spi_dc),
    .byte_valid    (byte_valid),
    .byte_data     (byte_data),
    .byte_dc       (byte_dc),
    .cs_end        (cs_end),
    .cs_end_partial(cs_end_partial)
  );

  assign pix_word  = {hi_byte, byte_data};
  assign in_bounds = (col < 16'(WIDTH)) && (row < 16'(HEIGHT));

  // byte stage: command decode, window capture and pixel write
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      param_cnt   <= 2'd0;
      start_w     <= 16'd0;
      end_hi      <= 8'd0;
      xs          <= 16'd0;
      xe          <= 16'(WIDTH - 1);
      ys          <= 16'd0;
      ye          <= 16'(HEIGHT - 1);
      col         <= 16'd0;
      row         <= 16'd0;
      half        <= 1'b0;
      hi_byte     <= 8'd0;
      pix_we      <= 1'b0;
      pix_addr    <= '0;
      pix_data    <= '0;
      cmd_valid   <= 1'b0;
      cmd_byte    <= 8'd0;
      frame_done  <= 1'b0;
      err_partial <= 1'b0;
    end else begin
      pix_we     <= 1'b0;
      cmd_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (byte_valid) begin
        if (!byte_dc) begin
          cmd_valid <= 1'b1;
          cmd_byte  <= byte_data;
          param_cnt <= 2'd0;
          half      <= 1'b0;
          case (byte_data)
            CMD_CASET: state <= CASET;
            CMD_RASET: state <= RASET;
            CMD_RAMWR: begin
              state <= RAMWR;
              col   <= xs;
              row   <= ys;
            end
            default:   state <= IGNORE;
          endcase
        end else begin
          case (state)
            CASET, RASET: begin
              param_cnt <= param_cnt + 2'd1;
              case (param_cnt)
                2'd0:    start_w[15:8] <= byte_data;
                2'd1:    start_w[7:0]  <= byte_data;
                2'd2:    end_hi        <= byte_data;
                default: begin
                  if (state == CASET) begin
                    xs <= start_w;
                    xe <= {end_hi, byte_data};
                  end else begin
                    ys <= start_w;
                    ye <= {end_hi, byte_data};
                  end
                  state <= IDLE;
                end
              endcase
            end
            RAMWR: begin
              if (!half) begin
                hi_byte <= byte_data;
                half    <= 1'b1;
              end else begin
                half <= 1'b0;
                if (in_bounds) begin
                  pix_we   <= 1'b1;
                  pix_addr <= AW'(row[RW-1:0]) * AW'(WIDTH) + AW'(col[CW-1:0]);
                  pix_data <= pix_word[PIXEL_SIZE-1:0];
                end
                // equality compare only, so an inverted window runs until wrap
                if (col == xe) begin
                  col <= xs;
                  if (row == ye) begin
                    row        <= ys;
                    frame_done <= 1'b1;
                  end else begin
                    row <= row + 16'd1;
                  end
                end else begin
                  col <= col + 16'd1;
                end
              end
            end
            default: ;
          endcase
        end
      end
      // a CS rise never coincides with byte_valid; a half pixel is dropped
      if (cs_end) begin
        half <= 1'b0;
        if (cs_end_partial || half) err_partial <= 1'b1;
      end
    end
  end

  assign bus.pix_we      = pix_we;
  assign bus.pix_addr    = pix_addr;
  assign bus.pix_data    = pix_data;
  assign bus.cmd_valid   = cmd_valid;
  assign bus.cmd_byte    = cmd_byte;
  assign bus.frame_done  = frame_done;
  assign bus.err_partial = err_partial;
endmodule

// File: tb/tb_ili9163_spi_sink.sv
// Scoreboard bench for ili9163_spi_sink: stimulus pushes expected pixel and
// command events, a negedge monitor pops and compares them.
module tb_ili9163_spi_sink;
  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  typedef struct {
    logic        we;
    logic [13:0] addr;
    logic [15:0] data;
    logic        fd;
  } pix_t;

  pix_t       pix_q[$];
  logic [7:0] cmd_q[$];

  ili9163_spi_sink_if #(.WIDTH(128), .HEIGHT(128), .PIXEL_SIZE(16)) bus ();

  ili9163_spi_sink #(.WIDTH(128), .HEIGHT(128), .PIXEL_SIZE(16)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic dcv, input logic [7:0] v, input int n);
    bus.spi_dc = dcv;
    for (int i = 7; i > 7 - n; i--) begin
      bus.spi_mosi = v[i];
      tick(4);
      bus.spi_sck = 1'b1;
      tick(4);
      bus.spi_sck = 1'b0;
    end
  endtask

  task automatic send_byte(input logic dcv, input logic [7:0] v);
    send_bits(dcv, v, 8);
  endtask

  task automatic send_cmd(input logic [7:0] b);
    cmd_q.push_back(b);
    send_byte(1'b0, b);
  endtask

  task automatic send_pixel(input logic [15:0] p);
    send_byte(1'b1, p[15:8]);
    send_byte(1'b1, p[7:0]);
  endtask

  task automatic exp_pix(input logic we, input int addr, input logic [15:0] data, input logic fd);
    pix_t e;
    e.we   = we;
    e.addr = 14'(addr);
    e.data = data;
    e.fd   = fd;
    pix_q.push_back(e);
  endtask

  task automatic cs_select();
    bus.spi_cs = 1'b0;
    tick(4);
  endtask

  task automatic do_reset();
    tick(8);
    check("drained_pix_q", pix_q.size(), 0);
    check("drained_cmd_q", cmd_q.size(), 0);
    bus.spi_cs = 1'b1;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.pix_we || bus.frame_done) begin
        if (pix_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL pix_unexpected: we=%0b fd=%0b addr=%0d data=%0h, none expected",
                   bus.pix_we, bus.frame_done, bus.pix_addr, bus.pix_data);
        end else begin
          pix_t e;
          e = pix_q.pop_front();
          check("pix_we", 32'(bus.pix_we), 32'(e.we));
          check("frame_done", 32'(bus.frame_done), 32'(e.fd));
          if (e.we) begin
            check("pix_addr", 32'(bus.pix_addr), 32'(e.addr));
            check("pix_data", 32'(bus.pix_data), 32'(e.data));
          end
        end
      end
      if (bus.cmd_valid) begin
        if (cmd_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL cmd_unexpected: cmd_byte=%0h, none expected", bus.cmd_byte);
        end else begin
          logic [7:0] b;
          b = cmd_q.pop_front();
          check("cmd_byte", 32'(bus.cmd_byte), 32'(b));
        end
      end
    end
  end

  initial begin
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: run exceeded 150000 cycles");
    $fatal(1);
  end

  initial begin
    compared     = 0;
    mismatched   = 0;
    rst          = 1'b1;
    bus.spi_cs   = 1'b1;
    bus.spi_sck  = 1'b0;
    bus.spi_mosi = 1'b0;
    bus.spi_dc   = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    check("rst_pix_we", 32'(bus.pix_we), 0);
    check("rst_pix_addr", 32'(bus.pix_addr), 0);
    check("rst_pix_data", 32'(bus.pix_data), 0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 0);
    check("rst_cmd_byte", 32'(bus.cmd_byte), 0);
    check("rst_frame_done", 32'(bus.frame_done), 0);
    check("rst_err_partial", 32'(bus.err_partial), 0);

    // full-screen default window: first 64 pixels land at 0..63
    cs_select();
    send_cmd(8'h2C);
    for (int i = 0; i < 64; i++) begin
      exp_pix(1'b1, i, 16'h07FF, 1'b0);
      send_pixel(16'h07FF);
    end

    // last row of the screen: 16256..16383 with frame_done on 16383
    send_cmd(8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h7F);
    send_cmd(8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h7F);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h7F);
    send_cmd(8'h2C);
    for (int i = 0; i < 128; i++) begin
      exp_pix(1'b1, 16256 + i, 16'h07FF, i == 127);
      send_pixel(16'h07FF);
    end

    // 4x2 window at cols 4..7, rows 2..3, then wrap to 260
    send_cmd(8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h04);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h07);
    send_cmd(8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h02);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h03);
    send_cmd(8'h2C);
    for (int i = 0; i < 9; i++) begin
      int a;
      a = (i == 8) ? 260 : ((i < 4) ? 260 + i : 388 + i - 4);
      exp_pix(1'b1, a, 16'(i + 1), i == 7);
      send_pixel(16'(i + 1));
    end

    // unknown command swallows its data bytes
    do_reset();
    cs_select();
    send_cmd(8'h11);
    send_byte(1'b1, 8'h55); send_byte(1'b1, 8'hAA); send_byte(1'b1, 8'h5A);
    send_cmd(8'h2C);
    exp_pix(1'b1, 0, 16'hF800, 1'b0);
    send_pixel(16'hF800);

    // CS drop mid-pixel: partial pixel dropped, err_partial latched
    do_reset();
    cs_select();
    send_cmd(8'h2C);
    send_byte(1'b1, 8'hAB);
    send_bits(1'b1, 8'hCD, 4);
    tick(4);
    bus.spi_cs = 1'b1;
    tick(8);
    check("err_partial_set", 32'(bus.err_partial), 1);
    cs_select();
    exp_pix(1'b1, 0, 16'h1234, 1'b0);
    send_pixel(16'h1234);

    // window straddling the right edge: cols 128/129 suppressed
    send_cmd(8'h2A);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h7E);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h81);
    send_cmd(8'h2B);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_byte(1'b1, 8'h00); send_byte(1'b1, 8'h00);
    send_cmd(8'h2C);
    exp_pix(1'b1, 126, 16'hC001, 1'b0);
    send_pixel(16'hC001);
    exp_pix(1'b1, 127, 16'hC002, 1'b0);
    send_pixel(16'hC002);
    send_pixel(16'hC003);
    exp_pix(1'b0, 0, 16'h0000, 1'b1);
    send_pixel(16'hC004);
    tick(8);
    check("err_partial_sticky", 32'(bus.err_partial), 1);

    // reset in the middle of a CASET parameter restores full screen
    do_reset();
    check("err_partial_cleared", 32'(bus.err_partial), 0);
    cs_select();
    send_cmd(8'h2A);
    send_byte(1'b1, 8'h00);
    send_bits(1'b1, 8'h05, 4);
    tick(8);
    check("pre_rst_pix_q", pix_q.size(), 0);
    check("pre_rst_cmd_q", cmd_q.size(), 0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);
    bus.spi_cs = 1'b1;
    tick(8);
    cs_select();
    send_cmd(8'h2C);
    exp_pix(1'b1, 0, 16'hBEEF, 1'b0);
    send_pixel(16'hBEEF);
    tick(12);
    check("err_after_rst_cs", 32'(bus.err_partial), 0);

    check("final_pix_q_empty", pix_q.size(), 0);
    check("final_cmd_q_empty", cmd_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ili9163_spi_sink.md
# ili9163_spi_sink

SPI responder for the ILI9163 display link: it receives the MOSI/SCK/CS/DC stream that our display controller drives, decodes command and data bytes, and tracks the column/row address window. Each RAMWR pixel is written into a frame-buffer write port at its linear address. It sits in the simulation and FPGA loop-back builds in place of the physical panel, so that frames sent by the top level can be captured and checked on-chip.

## Interface
Parameters:
- WIDTH, 128, panel columns
- HEIGHT, 128, panel rows
- PIXEL_SIZE, 16, bits per pixel (RGB565)

Ports:
- clk  in  1  system clock (50 MHz); the only clock, all SPI inputs are sampled in this domain
- rst  in  1  synchronous, active-high reset
- spi_mosi  in  1  serial data, MSB first
- spi_sck  in  1  SPI clock, mode 0 (sample on rising edge)
- spi_cs  in  1  chip select, active low
- spi_dc  in  1  0 = command byte, 1 = data byte
- pix_we  out  1  one-cycle pixel write strobe
- pix_addr  out  $clog2(WIDTH*HEIGHT)  linear address row*WIDTH+col
- pix_data  out  PIXEL_SIZE  pixel value
- cmd_valid  out  1  one-cycle strobe per received command byte
- cmd_byte  out  8  last command byte
- frame_done  out  1  one-cycle strobe when the last pixel of the window is written
- err_partial  out  1  sticky; set when CS deasserts with a partial byte or partial pixel pending; cleared only by rst

## Operation
- Input conditioning: 2-flop synchronizers on sck, cs, mosi and dc. Rising-edge detect on synchronized sck.
- Byte assembly: on each sck rising edge with cs low, shift mosi into an 8-bit register and increment a 3-bit counter. On the 8th bit, emit byte_valid together with dc sampled at that edge.
- CS high: clears the bit counter and discards any partial byte. Command state, window and cursor are retained, so per-byte CS toggling is legal.
- FSM states:
  - IDLE: data bytes are ignored.
  - Any command byte (dc=0), in any state: pulse cmd_valid, latch cmd_byte, then go to CASET (0x2A), RASET (0x2B), RAMWR (0x2C) or IGNORE (other values).
  - A command byte always aborts the current state, discarding pending parameter bytes and any half pixel.
- CASET/RASET:
  - Four data bytes: start hi, start lo, end hi, end lo.
  - On the 4th byte, commit {start, end} to xs/xe (or ys/ye), then go to IDLE.
  - Further data bytes in IDLE are ignored.
- RAMWR:
  - Entry sets the cursor col=xs, row=ys.
  - Data bytes pair hi then lo into a pixel. Each completed pixel drives pix_we, pix_data and pix_addr from the current cursor, then the cursor advances.
  - Cursor advance: if col==xe, then col=xs and row advances; otherwise col+1.
  - At col==xe and row==ye: pulse frame_done, wrap the cursor to (xs, ys) and stay in RAMWR.
- Bounds: a pixel with col>=WIDTH or row>=HEIGHT suppresses pix_we, but the cursor still advances.
- Inverted window (xs>xe or ys>ye): the wrap compare uses equality only. Behaviour is defined as continuing until the 16-bit counter wraps; this case is not a verification target.
- IGNORE: swallow data bytes until the next command byte.
- Reset values:
  - pix_we=0, pix_addr=0, pix_data=0, cmd_valid=0, cmd_byte=0, frame_done=0, err_partial=0.
  - Window xs=0, xe=WIDTH-1, ys=0, ye=HEIGHT-1.
  - FSM in IDLE; bit counter, parameter counter and half-pixel flag all 0.
- Width rules: window registers and cursor are 16 bits, compared at full width. pix_addr = row[log2 H-1:0]*WIDTH + col[log2 W-1:0], computed only when in bounds.

## Timing
- Synchronizer plus edge detect: the 8th sck rising edge becomes visible as byte_valid 3 clk cycles later.
- cmd_valid and the FSM transition occur in the cycle after byte_valid.
- pix_we occurs in the cycle after the lo byte's byte_valid, i.e. 4 clk after the 16th sck rising edge. frame_done is coincident with pix_we of the last pixel.
- sck high and low phases must each be ≥3 clk periods, so max sck = clk/6. Faster input is out of spec.
- cs low-to-first-sck-edge must be ≥3 clk periods.
- Simultaneous byte completion and CS rise in the same synchronized cycle: the byte completes first, then the clear takes effect.
- rst mid-transfer: all state returns to reset values on the next clk edge. Partial bytes are lost and the window reverts to full screen.

## Structure
- Package ili9163_pkg:
  - CMD_CASET=8'h2A, CMD_RASET=8'h2B, CMD_RAMWR=8'h2C.
  - FSM state enum {IDLE, CASET, RASET, RAMWR, IGNORE}.
  - PIXEL_SIZE default.
- Sub-module spi_byte_rx: synchronizers, sck edge detect, shift register and bit counter. Outputs byte_valid, byte_data[7:0] and byte_dc.
- The top of the block holds the FSM, window registers, cursor and address arithmetic.

## Test plan
- Reset, then RAMWR followed by 128*128 pixels of 16'h07FF with no CASET/RASET -> 16384 pix_we with addresses 0..16383 in order and data 07FF, and a single frame_done on address 16383.
- CASET 0x0004..0x0007, RASET 0x0002..0x0003, RAMWR, then 8 pixels 0x0001..0x0008 -> addresses 260..263 and 388..391, then frame_done; a 9th pixel writes address 260.
- Command 0x11 followed by 3 data bytes, then 0x2C and pixel 0xF800 -> cmd_valid twice with cmd_byte 11 then 2C, and one pix_we with data F800 at address 0.
- RAMWR, hi byte 0xAB, then CS high after 4 bits of the lo byte, then full bytes 0x12, 0x34 -> err_partial=1 and one pix_we with data 0x1234. The partial pixel is dropped.
- CASET 0x007E..0x0081 then RAMWR with 4 pixels -> pix_we only for cols 126 and 127; frame_done still pulses after the 4th pixel.
- Assert rst during the 2nd CASET parameter, then RAMWR with 1 pixel -> written at address 0 with the full-screen window.
